// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the write-back stage.
// The MEM/WB register, scoreboard and bypass logic all use these definitions.
package rf_pkg;

    localparam int REG_AW = 5;
    localparam int NREG   = 32;
    localparam int DW     = 32;
    localparam int CNT_W  = 2;

    // Encoding 3 is reserved and falls back to the ALU result
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LD   = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic              regwr;
        logic [REG_AW-1:0] rd;
    } wb_ctl_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register in-flight write counters: raises id_stall while an ID source
// still waits for its final value, and latches sb_err on counter over/underflow.
module wb_scoreboard
    import rf_pkg::REG_AW;
#(
    parameter int NREG  = rf_pkg::NREG,
    parameter int CNT_W = rf_pkg::CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              iss_valid,
    input  logic              iss_regwr,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              kill_valid,
    input  logic [REG_AW-1:0] kill_rd,
    input  logic              WrEn,
    input  logic [REG_AW-1:0] Rw,
    input  logic [REG_AW-1:0] id_Ra,
    input  logic [REG_AW-1:0] id_Rb,
    output logic              id_stall,
    output logic              sb_err
);

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};
    localparam logic [CNT_W+1:0] ONE_EXT = {{(CNT_W+1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cntReg  [NREG];
    logic [CNT_W-1:0] cntNext [NREG];
    logic [NREG-1:0]  errVec;
    logic             sbErrReg;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign cntNext[gi] = '0;
                assign errVec[gi]  = 1'b0;
            end else begin : g_reg
                localparam logic [REG_AW-1:0] RIDX = REG_AW'(gi);
                logic             inc;
                logic             decW;
                logic             decK;
                logic [CNT_W+1:0] up;
                logic [CNT_W+1:0] dec;
                logic [CNT_W+1:0] diff;
                logic             underflow;
                logic             overflow;

                assign inc  = iss_valid & iss_regwr & (iss_rd == RIDX);
                assign decW = WrEn & (Rw == RIDX);
                assign decK = kill_valid & (kill_rd == RIDX);

                // Two extra bits leave room for cnt+1 and a double decrement
                assign up   = {2'b00, cntReg[gi]} + (inc ? ONE_EXT : '0);
                assign dec  = (decW ? ONE_EXT : '0) + (decK ? ONE_EXT : '0);
                assign diff = up - dec;

                assign underflow = (up < dec);
                assign overflow  = ~underflow & (diff > CNT_MAX);

                assign cntNext[gi] = underflow ? '0 :
                                     overflow  ? CNT_MAX[CNT_W-1:0] :
                                                 diff[CNT_W-1:0];
                assign errVec[gi]  = underflow | overflow;
            end
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < NREG; r++) begin
                cntReg[r] <= '0;
            end
            sbErrReg <= 1'b0;
        end else begin
            cntReg   <= cntNext;
            sbErrReg <= sbErrReg | (|errVec);
        end
    end

    // A source resolves this cycle only if the current write is its last one
    logic [REG_AW-1:0] srcAddr  [2];
    logic [1:0]        srcStall;

    assign srcAddr[0] = id_Ra;
    assign srcAddr[1] = id_Rb;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [CNT_W-1:0] srcCnt;
            logic             bypassed;

            assign srcCnt       = cntReg[srcAddr[gi]];
            assign bypassed     = WrEn & (Rw == srcAddr[gi]) & (srcCnt == CNT_W'(1));
            assign srcStall[gi] = (srcCnt != '0) & ~bypassed;
        end
    endgenerate

    assign id_stall = |srcStall;
    assign sb_err   = sbErrReg;

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: MEM/WB register, result select, register-file write port,
// bypass of the pending write to the ID read ports, and the write scoreboard.
module wb_writer
    import rf_pkg::REG_AW, rf_pkg::ZERO_REG, rf_pkg::WB_SEL_ALU,
           rf_pkg::WB_SEL_LD, rf_pkg::WB_SEL_LINK, rf_pkg::wb_ctl_t;
#(
    parameter int NREG  = rf_pkg::NREG,
    parameter int DW    = rf_pkg::DW,
    parameter int CNT_W = rf_pkg::CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              mem_valid,
    input  logic              mem_regwr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [1:0]        mem_sel,
    input  logic [DW-1:0]     mem_alu,
    input  logic [DW-1:0]     mem_ld,
    input  logic [DW-1:0]     mem_link,
    input  logic              wb_stall,
    input  logic              iss_valid,
    input  logic              iss_regwr,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              kill_valid,
    input  logic [REG_AW-1:0] kill_rd,
    input  logic [REG_AW-1:0] id_Ra,
    input  logic [REG_AW-1:0] id_Rb,
    input  logic [DW-1:0]     rf_busA,
    input  logic [DW-1:0]     rf_busB,
    output logic              WrEn,
    output logic [REG_AW-1:0] Rw,
    output logic [DW-1:0]     busW,
    output logic [DW-1:0]     id_busA,
    output logic [DW-1:0]     id_busB,
    output logic              id_stall,
    output logic              sb_err
);

    wb_ctl_t       wbCtlReg;
    logic [DW-1:0] wbDataReg;
    logic [DW-1:0] memResult;

    always_comb begin
        memResult = mem_alu;
        case (mem_sel)
            WB_SEL_ALU:  memResult = mem_alu;
            WB_SEL_LD:   memResult = mem_ld;
            WB_SEL_LINK: memResult = mem_link;
            default:     memResult = mem_alu;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wbCtlReg  <= '0;
            wbDataReg <= '0;
        end else if (!wb_stall) begin
            wbCtlReg.valid <= mem_valid;
            wbCtlReg.regwr <= mem_regwr;
            wbCtlReg.rd    <= mem_rd;
            wbDataReg      <= memResult;
        end
    end

    // Masking with wb_stall keeps a held entry from being written twice
    assign WrEn = wbCtlReg.valid & wbCtlReg.regwr & (wbCtlReg.rd != ZERO_REG) & ~wb_stall;
    assign Rw   = wbCtlReg.rd;
    assign busW = wbDataReg;

    logic [REG_AW-1:0] srcAddr [2];
    logic [DW-1:0]     rfData  [2];
    logic [DW-1:0]     bypData [2];

    assign srcAddr[0] = id_Ra;
    assign srcAddr[1] = id_Rb;
    assign rfData[0]  = rf_busA;
    assign rfData[1]  = rf_busB;

    // The register file only commits on the next edge, so forward busW now
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_byp
            assign bypData[gi] = (srcAddr[gi] == ZERO_REG)     ? '0   :
                                 (WrEn && (Rw == srcAddr[gi])) ? busW :
                                                                 rfData[gi];
        end
    endgenerate

    assign id_busA = bypData[0];
    assign id_busB = bypData[1];

    wb_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .Clk        (Clk),
        .Reset      (Reset),
        .iss_valid  (iss_valid),
        .iss_regwr  (iss_regwr),
        .iss_rd     (iss_rd),
        .kill_valid (kill_valid),
        .kill_rd    (kill_rd),
        .WrEn       (WrEn),
        .Rw         (Rw),
        .id_Ra      (id_Ra),
        .id_Rb      (id_Rb),
        .id_stall   (id_stall),
        .sb_err     (sb_err)
    );

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: write port timing, bypass, scoreboard stalls,
// kill/write-back collisions, wb_stall hold and asynchronous reset.
module tb_wb_writer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        mem_valid, mem_regwr;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_sel;
    logic [31:0] mem_alu, mem_ld, mem_link;
    logic        wb_stall;
    logic        iss_valid, iss_regwr;
    logic [4:0]  iss_rd;
    logic        kill_valid;
    logic [4:0]  kill_rd;
    logic [4:0]  id_Ra, id_Rb;
    logic [31:0] rf_busA, rf_busB;
    logic        WrEn;
    logic [4:0]  Rw;
    logic [31:0] busW, id_busA, id_busB;
    logic        id_stall, sb_err;

    int nAssert = 0;
    int nFail   = 0;

    wb_writer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .mem_valid  (mem_valid),
        .mem_regwr  (mem_regwr),
        .mem_rd     (mem_rd),
        .mem_sel    (mem_sel),
        .mem_alu    (mem_alu),
        .mem_ld     (mem_ld),
        .mem_link   (mem_link),
        .wb_stall   (wb_stall),
        .iss_valid  (iss_valid),
        .iss_regwr  (iss_regwr),
        .iss_rd     (iss_rd),
        .kill_valid (kill_valid),
        .kill_rd    (kill_rd),
        .id_Ra      (id_Ra),
        .id_Rb      (id_Rb),
        .rf_busA    (rf_busA),
        .rf_busB    (rf_busB),
        .WrEn       (WrEn),
        .Rw         (Rw),
        .busW       (busW),
        .id_busA    (id_busA),
        .id_busB    (id_busB),
        .id_stall   (id_stall),
        .sb_err     (sb_err)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1;
        mem_valid = 1'b0; mem_regwr = 1'b0; mem_rd = 5'd0; mem_sel = 2'd0;
        mem_alu = '0; mem_ld = '0; mem_link = '0; wb_stall = 1'b0;
        iss_valid = 1'b0; iss_regwr = 1'b0; iss_rd = 5'd0;
        kill_valid = 1'b0; kill_rd = 5'd0;
        id_Ra = 5'd0; id_Rb = 5'd0; rf_busA = '0; rf_busB = '0;

        // Reset state
        tick(); tick();
        chk("rst_wren", WrEn, 1'b0);
        chk("rst_rw", Rw, 5'd0);
        chk("rst_busw", busW, 32'h0);
        chk("rst_stall", id_stall, 1'b0);
        chk("rst_err", sb_err, 1'b0);
        #1 Reset = 1'b0;
        $display("step reset: done");

        // Issue R10, write 0x7 through the ALU path
        tick();
        iss_valid = 1'b1; iss_regwr = 1'b1; iss_rd = 5'd10; id_Rb = 5'd10;
        #1 chk("a_stall_pre", id_stall, 1'b0);
        tick();
        iss_valid = 1'b0;
        mem_valid = 1'b1; mem_regwr = 1'b1; mem_rd = 5'd10; mem_sel = 2'd0; mem_alu = 32'h7;
        #1 chk("a_stall_pend", id_stall, 1'b1);
        tick();
        mem_valid = 1'b0; id_Ra = 5'd10; rf_busA = 32'h99;
        #1;
        chk("a_wren", WrEn, 1'b1);
        chk("a_rw", Rw, 5'd10);
        chk("a_busw", busW, 32'h7);
        chk("a_byp_a", id_busA, 32'h7);
        chk("a_stall_wb", id_stall, 1'b0);
        tick();
        rf_busA = 32'h7;
        #1;
        chk("a_wren_off", WrEn, 1'b0);
        chk("a_read_r10", id_busA, 32'h7);
        chk("a_stall_done", id_stall, 1'b0);
        $display("step R10 write: done");

        // Write to R0 is suppressed and R0 reads as zero
        tick();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_alu = 32'hFFFF;
        tick();
        mem_valid = 1'b0; id_Ra = 5'd0; rf_busA = 32'h1234;
        #1;
        chk("z_wren", WrEn, 1'b0);
        chk("z_busw", busW, 32'hFFFF);
        chk("z_read_r0", id_busA, 32'h0);
        $display("step R0 write: done");

        // Same-cycle hazard on R11, load path
        tick();
        iss_valid = 1'b1; iss_rd = 5'd11;
        tick();
        iss_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd11; mem_sel = 2'd1;
        mem_ld = 32'h20; mem_alu = 32'h55; mem_link = 32'h66;
        tick();
        mem_valid = 1'b0; id_Ra = 5'd11; rf_busA = 32'd15; id_Rb = 5'd3; rf_busB = 32'h33;
        #1;
        chk("h_wren", WrEn, 1'b1);
        chk("h_rw", Rw, 5'd11);
        chk("h_busw_ld", busW, 32'h20);
        chk("h_byp_a", id_busA, 32'h20);
        chk("h_nobyp_b", id_busB, 32'h33);
        chk("h_stall", id_stall, 1'b0);
        $display("step R11 hazard: done");

        // R20 stalls ID until its write-back cycle, link path
        tick();
        iss_valid = 1'b1; iss_rd = 5'd20; id_Ra = 5'd0; id_Rb = 5'd20; rf_busB = 32'h0;
        tick();
        iss_valid = 1'b0;
        #1 chk("s_stall_1", id_stall, 1'b1);
        tick();
        mem_valid = 1'b1; mem_rd = 5'd20; mem_sel = 2'd2; mem_link = 32'h108; mem_alu = 32'h1;
        #1 chk("s_stall_2", id_stall, 1'b1);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("s_wren", WrEn, 1'b1);
        chk("s_busw_link", busW, 32'h108);
        chk("s_byp_b", id_busB, 32'h108);
        chk("s_stall_wb", id_stall, 1'b0);
        tick();
        chk("s_stall_after", id_stall, 1'b0);
        $display("step R20 stall: done");

        // Two issues to R5; kill one while the other writes back (sel 3 -> ALU)
        tick();
        iss_valid = 1'b1; iss_rd = 5'd5; id_Rb = 5'd0;
        tick();
        tick();
        iss_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd5; mem_sel = 2'd3; mem_alu = 32'hAB; mem_ld = 32'hCD;
        id_Ra = 5'd5;
        #1 chk("k_stall_cnt2", id_stall, 1'b1);
        tick();
        mem_valid = 1'b0; kill_valid = 1'b1; kill_rd = 5'd5;
        #1;
        chk("k_wren", WrEn, 1'b1);
        chk("k_busw_rsvd", busW, 32'hAB);
        chk("k_stall_nobyp", id_stall, 1'b1);
        tick();
        kill_valid = 1'b0;
        #1;
        chk("k_stall_clear", id_stall, 1'b0);
        chk("k_err", sb_err, 1'b0);
        $display("step R5 kill+writeback: done");

        // wb_stall holds a pending load for 3 cycles, then exactly one write
        tick();
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_sel = 2'd1; mem_ld = 32'hCAFE;
        tick();
        mem_valid = 1'b0; wb_stall = 1'b1; id_Ra = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("w_hold_wren_%0d", i), WrEn, 1'b0);
            chk($sformatf("w_hold_stall_%0d", i), id_stall, 1'b1);
            tick();
        end
        wb_stall = 1'b0;
        #1;
        chk("w_rel_wren", WrEn, 1'b1);
        chk("w_rel_rw", Rw, 5'd7);
        chk("w_rel_busw", busW, 32'hCAFE);
        chk("w_rel_stall", id_stall, 1'b0);
        tick();
        chk("w_once", WrEn, 1'b0);
        chk("w_stall_done", id_stall, 1'b0);
        $display("step wb_stall hold: done");

        // Reset mid-stall discards the pending write to R8
        tick();
        iss_valid = 1'b1; iss_rd = 5'd8;
        tick();
        iss_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_sel = 2'd0; mem_alu = 32'h88;
        tick();
        mem_valid = 1'b0; wb_stall = 1'b1; id_Ra = 5'd8;
        #1 chk("r_hold_stall", id_stall, 1'b1);
        #1 Reset = 1'b1;
        #1;
        chk("r_wren", WrEn, 1'b0);
        chk("r_rw", Rw, 5'd0);
        chk("r_busw", busW, 32'h0);
        chk("r_stall", id_stall, 1'b0);
        tick();
        Reset = 1'b0; wb_stall = 1'b0;
        #1 chk("r_no_write", WrEn, 1'b0);
        tick();
        chk("r_no_write_2", WrEn, 1'b0);
        $display("step reset mid-stall: done");

        // Killing an idle register underflows and sets the sticky error
        tick();
        kill_valid = 1'b1; kill_rd = 5'd9;
        tick();
        kill_valid = 1'b0;
        #1 chk("e_err_set", sb_err, 1'b1);
        tick();
        chk("e_err_sticky", sb_err, 1'b1);
        $display("step underflow: done");

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/wb_writer.md
# wb_writer

Write-back stage: the writer side of the pipeline register file's single write port. It registers the MEM/WB pipeline boundary, selects the result, and drives WrEn/Rw/busW. The register file commits on the next rising Clk, so this block also bypasses that pending write to the ID read ports. A per-register scoreboard tracks in-flight writes and raises a stall for ID when a source has no final value yet.

## Interface
- Parameters
  - NREG, 32: architectural register count; register 0 is hard-wired zero.
  - DW, 32: data width.
  - CNT_W, 2: scoreboard counter width per register (max 3 in flight).
- Ports
  - Clk  in  1  pipeline clock; all state updates on the rising edge.
  - Reset  in  1  asynchronous, active-high reset.
  - mem_valid  in  1  MEM stage holds a valid instruction.
  - mem_regwr  in  1  instruction writes a register.
  - mem_rd  in  5  destination register.
  - mem_sel  in  2  result select: 0 ALU, 1 load data, 2 link (pc+8); 3 reserved, treated as ALU.
  - mem_alu  in  DW  ALU result.
  - mem_ld  in  DW  load data.
  - mem_link  in  DW  link value.
  - wb_stall  in  1  hold the MEM/WB register.
  - iss_valid, iss_regwr  in  1 each  ID issues an instruction that will write iss_rd.
  - iss_rd  in  5  issuing destination.
  - kill_valid  in  1  an issued, not-yet-written instruction is squashed.
  - kill_rd  in  5  squashed destination.
  - id_Ra, id_Rb  in  5 each  ID source addresses.
  - rf_busA, rf_busB  in  DW each  raw register file read data.
  - WrEn  out  1  register file write enable.
  - Rw  out  5  write address.
  - busW  out  DW  write data.
  - id_busA, id_busB  out  DW each  bypassed ID operands.
  - id_stall  out  1  a source register has a pending write.
  - sb_err  out  1  sticky: a counter overflowed or underflowed.

## Operation
- MEM/WB register fields: valid, regwr, rd, data, where data = mux(mem_sel).
  - Loads on each edge unless wb_stall.
  - While wb_stall is high, contents hold; WrEn is forced to 0, so no duplicate write.
- WrEn = wb_valid & wb_regwr & (wb_rd != 0) & ~wb_stall; Rw = wb_rd; busW = wb_data.
- Bypass:
  - id_busA = 0 if id_Ra == 0.
  - Otherwise id_busA = busW if WrEn & (Rw == id_Ra), else rf_busA.
  - id_busB likewise with id_Rb and rf_busB.
- Scoreboard: cnt[r] for r = 1..NREG-1; cnt[0] is constant 0.
  - inc[r] = iss_valid & iss_regwr & (iss_rd == r).
  - dec[r] = (WrEn & Rw == r) + (kill_valid & kill_rd == r). Dec can be 2.
  - cnt[r] next = cnt[r] + inc - dec, applied in one step. Simultaneous inc and dec of 1 leaves cnt unchanged.
  - Overflow (would exceed 3) or underflow (would go below 0): cnt saturates at 3 or 0, and sb_err sets. sb_err clears only on Reset.
- id_stall = (cnt[id_Ra] != 0 & ~bypassed A) | (cnt[id_Rb] != 0 & ~bypassed B).
  - A source is "bypassed" only when WrEn targets it this cycle and that write is its last pending write (cnt == 1).

## Timing
- Reset values: MEM/WB valid = 0, rd = 0, data = 0; all cnt = 0; sb_err = 0. Hence WrEn = 0, Rw = 0, busW = 0, id_stall = 0.
- Reset asserted mid-operation discards the in-flight write; no WrEn pulse occurs in the Reset cycle.
- Latency:
  - MEM inputs appear on WrEn/Rw/busW one cycle later.
  - The register file holds the value one further edge later.
  - The bypass covers the cycle between those two.
- Scoreboard updates take effect on the next edge. id_stall is combinational from the current cnt and current WrEn.

## Structure
- Shared package rf_pkg:
  - REG_AW = 5, NREG, DW.
  - WB_SEL_ALU/LD/LINK constants.
  - Zero-register constant.
- Sub-module wb_scoreboard holds the counter array, the inc/dec logic, id_stall and sb_err.
- The top level holds the MEM/WB register, the result mux, the write-port logic and the bypass.

## Test plan
- Reset, then a MEM instruction with rd = 10, sel = ALU, alu = 0x7 -> next cycle WrEn = 1, Rw = 10, busW = 0x7; a following read of R10 returns 7.
- Write to rd = 0 with data 0xFFFF -> WrEn = 0; id_busA for Ra = 0 is 0.
- Same-cycle hazard: WrEn to R11 with 0x20 while id_Ra = 11 and rf_busA = 15 -> id_busA = 0x20.
- Issue rd = 20, then ID reads Rb = 20 -> id_stall = 1 until the write-back cycle; id_stall = 0 in the WrEn cycle (cnt was 1).
- Issue rd = 5 twice; kill one while the other writes back in the same cycle -> cnt[5]: 2 -> 0, sb_err stays 0.
- wb_stall high for 3 cycles with a load pending -> WrEn = 0 throughout, exactly one write after release; Reset mid-stall -> no write occurs, all outputs return to 0.
